// File: rtl/wb_master_if.sv
// Wishbone classic master bridging a single-access CPU port onto the bus.
// One transfer at a time: IDLE issues a cycle, BUSY holds it until ack,
// timeout or flush, WAIT_FOR_STALL parks the read data while the pipeline
// is stalled.
module wb_master_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StWaitForStall} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        start_req;
  logic        timeout_hit;

  assign start_req   = cpu_ce_i && !flush_i;
  // Timeout is judged without flush; flush still wins in the next-state logic.
  assign timeout_hit = (state_q == StBusy) && !wb_ack_i && (cnt_q == TimeoutLast);

  // State and bus registers, cleared asynchronously so the bus drops at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic: hold everything by default, error pulse self-clears.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rd_buf_d  = rd_buf_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = cpu_we_i;
          adr_d   = cpu_addr_i;
          dat_d   = cpu_data_i;
          sel_d   = cpu_sel_i;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (flush_i) begin
          // Master abort: ack data is dropped and the read buffer kept.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          dat_d   = '0;
          sel_d   = '0;
          state_d = StIdle;
        end else if (wb_ack_i || timeout_hit) begin
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          we_d      = 1'b0;
          adr_d     = '0;
          dat_d     = '0;
          sel_d     = '0;
          rd_buf_d  = (wb_ack_i && !we_q) ? wb_dat_i : 32'h0;
          bus_err_d = !wb_ack_i;
          state_d   = stall_i ? StWaitForStall : StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StWaitForStall: begin
        if (!stall_i || flush_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // CPU-facing outputs: stall request and read data bypass are combinational
  // so a combinational ack completes in the strobe cycle.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    unique case (state_q)
      StIdle: stallreq_o = start_req;
      StBusy: begin
        stallreq_o = !(wb_ack_i || flush_i || timeout_hit);
        if (wb_ack_i && !we_q) begin
          cpu_data_o = wb_dat_i;
        end
      end
      StWaitForStall: cpu_data_o = rd_buf_q;
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
      end
    endcase
  end

  assign bus_err_o = bus_err_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;

endmodule

// File: tb/tb_wb_master_if.sv
// Bench for wb_master_if: table of directed transfers, randomized transfers
// checked against a transfer-level model, and hand-written corner sequences.
module tb_wb_master_if;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, we = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;
  logic [31:0] cpu_data;
  logic        stallreq, bus_err;
  logic        cyc, stb, wb_we;
  logic [31:0] adr, dat;
  logic [3:0]  wb_sel;
  logic [31:0] slave_data = '0;
  logic        ack;
  logic        force_ack = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt = 0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  wb_master_if #(.TIMEOUT(TO)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cpu_ce_i   (ce),
    .cpu_we_i   (we),
    .cpu_addr_i (addr),
    .cpu_data_i (wdata),
    .cpu_sel_i  (sel),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_data_o (cpu_data),
    .stallreq_o (stallreq),
    .bus_err_o  (bus_err),
    .wb_cyc_o   (cyc),
    .wb_stb_o   (stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (adr),
    .wb_dat_o   (dat),
    .wb_sel_o   (wb_sel),
    .wb_dat_i   (slave_data),
    .wb_ack_i   (ack)
  );

  // Slave: acks combinationally once the strobe has waited ack_delay cycles.
  assign ack = force_ack || (stb && (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (!stb || ack) wait_cnt <= 0;
    else             wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          delay;
    int          stall;
    logic [31:0] rdata;
    int          exp_cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: ack after 'delay' waits unless the timeout expires first.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err    = (v.delay >= int'(TO));
    r.exp_cycles = r.exp_err ? int'(TO) : v.delay + 1;
    r.exp_rdata  = (r.exp_err || v.we) ? 32'h0 : v.rdata;
    return r;
  endfunction

  task automatic run_txn(input vec_t v);
    logic last;
    @(posedge clk); #1;
    ce = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; sel = v.sel;
    slave_data = v.rdata; ack_delay = v.delay; stall = 1'b0;
    @(negedge clk);
    check1("req_stallreq", stallreq, 1'b1);
    check1("req_cyc_idle", cyc, 1'b0);
    @(posedge clk); #1;
    ce = 1'b0; stall = (v.stall > 0);
    for (int i = 0; i < v.exp_cycles; i++) begin
      @(negedge clk);
      last = (i == v.exp_cycles - 1);
      check1("busy_cyc", cyc, 1'b1);
      check1("busy_stb", stb, 1'b1);
      check1("busy_we", wb_we, v.we);
      check32("busy_adr", adr, v.addr);
      check32("busy_dat", dat, v.wdata);
      check32("busy_sel", {28'h0, wb_sel}, {28'h0, v.sel});
      check1("busy_stallreq", stallreq, !last);
      check32("busy_cpu_data", cpu_data, last ? v.exp_rdata : 32'h0);
      @(posedge clk); #1;
    end
    for (int j = 0; j < v.stall; j++) begin
      stall = (j < v.stall - 1);
      @(negedge clk);
      check1("wait_cyc", cyc, 1'b0);
      check1("wait_stallreq", stallreq, 1'b0);
      check32("wait_cpu_data", cpu_data, v.exp_rdata);
      if (j == 0) check1("wait_bus_err", bus_err, v.exp_err);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    if (v.stall == 0) check1("post_bus_err", bus_err, v.exp_err);
    check1("post_cyc", cyc, 1'b0);
    check32("post_cpu_data", cpu_data, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("post_bus_err_clear", bus_err, 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    // we, addr, wdata, sel, delay, stall, rdata | cycles, rdata, err
    tbl[0] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'h3, 3, 0, 32'hFFFF_FFFF, 4, 32'h0, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0040, 32'h0, 4'hF, 9, 0, 32'h1111_2222, 4, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0050, 32'hA5A5_5A5A, 4'hC, 2, 1, 32'h7777_8888, 3, 32'h0, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0060, 32'h0, 4'h1, 7, 2, 32'h3333_4444, 4, 32'h0, 1'b1};

    // Reset state, no clock edge needed.
    #3;
    check1("rst_cyc", cyc, 1'b0);
    check1("rst_stb", stb, 1'b0);
    check1("rst_we", wb_we, 1'b0);
    check32("rst_adr", adr, 32'h0);
    check32("rst_dat", dat, 32'h0);
    check1("rst_bus_err", bus_err, 1'b0);
    check1("rst_stallreq", stallreq, 1'b0);
    check32("rst_cpu_data", cpu_data, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 6; k++) run_txn(tbl[k]);

    // Request with flush in IDLE must not start a cycle.
    @(posedge clk); #1;
    ce = 1'b1; flush = 1'b1; addr = 32'h0000_0070;
    @(negedge clk);
    check1("flushreq_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    ce = 1'b0; flush = 1'b0;
    @(negedge clk);
    check1("flushreq_cyc", cyc, 1'b0);

    // Ack while idle is ignored.
    @(posedge clk); #1;
    force_ack = 1'b1; slave_data = 32'h9999_9999;
    @(negedge clk);
    check32("idle_ack_cpu_data", cpu_data, 32'h0);
    check1("idle_ack_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    check1("idle_ack_cyc", cyc, 1'b0);
    check1("idle_ack_bus_err", bus_err, 1'b0);

    // Flush coincident with ack: no data kept, IDLE (not WAIT) despite stall.
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b0; addr = 32'h0000_0080; sel = 4'hF;
    slave_data = 32'hA5A5_A5A5; ack_delay = 1;
    @(posedge clk); #1;
    ce = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check1("flush_ack_stallreq", stallreq, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check1("flush_ack_cyc", cyc, 1'b0);
    check32("flush_ack_cpu_data", cpu_data, 32'h0);
    check1("flush_ack_bus_err", bus_err, 1'b0);
    check1("flush_ack_stallreq_idle", stallreq, 1'b0);
    @(posedge clk); #1;
    stall = 1'b0;

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    ce = 1'b1; we = 1'b1; addr = 32'h0000_0090; wdata = 32'h5555_AAAA; ack_delay = 9;
    @(posedge clk); #1;
    ce = 1'b0;
    @(negedge clk);
    check1("pre_rst_cyc", cyc, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("async_rst_cyc", cyc, 1'b0);
    check1("async_rst_stb", stb, 1'b0);
    check32("async_rst_adr", adr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(model('{1'b0, 32'h0000_00A0, 32'h0, 4'hF, 2, 0, 32'h0BAD_F00D, 0, 32'h0, 1'b0}));

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.we    = 1'($urandom);
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.sel   = 4'($urandom);
      v.delay = int'($urandom_range(0, 5));
      v.stall = int'($urandom_range(0, 2));
      v.rdata = $urandom;
      v.exp_cycles = 0;
      v.exp_rdata  = '0;
      v.exp_err    = 1'b0;
      run_txn(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_master_if.md
WB_MASTER_IF -- requirements
Module: wb_master_if

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning BUSY cycles without wb_ack_i before abort (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- wb_clk_i  in  1  sole clock; all state changes on its rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- cpu_ce_i  in  1  CPU access request
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  write data
- cpu_sel_i  in  4  byte lanes
- stall_i  in  1  pipeline stall from other stages
- flush_i  in  1  exception flush
- cpu_data_o  out  32  read data to CPU
- stallreq_o  out  1  stall request to pipeline
- bus_err_o  out  1  one-cycle timeout pulse
- wb_cyc_o  out  1  cycle valid
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select
- wb_dat_i  in  32  slave read data
- wb_ack_i  in  1  slave acknowledge (may be combinational from stb)

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, WAIT_FOR_STALL; all wb_* outputs, the read buffer, timeout counter and state SHALL be registered.
REQ-004 IDLE with cpu_ce_i=1 and flush_i=0 SHALL, at the next edge, drive wb_cyc_o=wb_stb_o=1 and latch wb_adr_o=cpu_addr_i, wb_dat_o=cpu_data_i, wb_sel_o=cpu_sel_i, wb_we_o=cpu_we_i, clear counter, and enter BUSY.
REQ-005 wb_* outputs SHALL hold stable throughout BUSY.
REQ-006 stallreq_o SHALL be combinational: 1 in IDLE when cpu_ce_i=1 and flush_i=0; 1 in BUSY unless wb_ack_i=1, flush_i=1, or timeout fires this cycle; 0 in WAIT_FOR_STALL.
REQ-007 BUSY with wb_ack_i=1 SHALL, at the next edge, clear cyc/stb/we to 0, sel/adr/dat to 0, store wb_dat_i into the read buffer on reads (0 on writes), and go to WAIT_FOR_STALL if stall_i=1, else IDLE.
REQ-008 cpu_data_o SHALL equal wb_dat_i in the BUSY cycle where wb_ack_i=1 and wb_we_o=0, the read buffer in WAIT_FOR_STALL, else 0.
REQ-009 Minimum latency: request in cycle N, strobe in N+1, with combinational ack stallreq_o drops in N+1 and read data is valid in N+1.
REQ-010 Counter (8 bits) SHALL increment each BUSY cycle without ack; when counter = TIMEOUT-1 and no ack, the next edge SHALL drop cyc/stb, pulse bus_err_o=1 for exactly one cycle, load the read buffer with 0, and follow the REQ-007 stall_i routing.
REQ-011 flush_i=1 in BUSY SHALL, at the next edge, drop cyc/stb (master abort), discard any ack data, leave the read buffer unchanged, and enter IDLE; flush_i has priority over wb_ack_i and timeout.
REQ-012 WAIT_FOR_STALL SHALL go to IDLE when stall_i=0 or flush_i=1.
REQ-013 wb_ack_i outside BUSY SHALL be ignored.
REQ-014 A request in IDLE with flush_i=1 SHALL NOT start a cycle.

Reset
REQ-015 wb_rst_i=1 SHALL immediately, without a clock edge, force IDLE, all wb_* outputs to 0, read buffer 0, counter 0, bus_err_o 0; stallreq_o then follows REQ-006 combinationally.
REQ-016 Reset mid-BUSY SHALL drop wb_cyc_o/wb_stb_o asynchronously; no data is delivered.

Verification
REQ-017 Read at 0x0000_0010, sel=4'hF, slave acks combinationally with 0xDEAD_BEEF -> strobe one cycle later; cpu_data_o=0xDEAD_BEEF and stallreq_o=0 in that cycle; next cycle wb_cyc_o=0.
REQ-018 Write 0x1234_5678 at 0x0000_0020, sel=4'h3, ack delayed 3 cycles -> wb_we_o=1, wb_sel_o=4'h3 stable 4 strobe cycles; stallreq_o=1 until the ack cycle.
REQ-019 Read acked while stall_i=1 for 2 cycles -> WAIT_FOR_STALL; cpu_data_o holds the ack data both cycles; IDLE after stall_i falls.
REQ-020 TIMEOUT=4, no ack -> 4 BUSY cycles, bus_err_o=1 for one cycle, wb_cyc_o=0, cpu_data_o=0.
REQ-021 flush_i=1 in the same cycle as wb_ack_i -> no data latched, IDLE next cycle, no bus_err_o.
REQ-022 wb_rst_i asserted mid-BUSY between edges -> wb_cyc_o=wb_stb_o=0 immediately; after release, a new request completes normally.
